// File: rtl/alu_serial_subtractor.sv
// Bit-serial subtractor: A-B computed LSB first through one full-subtractor cell,
// delivered as a sign-extended 2*WIDTH two's-complement result with a done pulse.
module alu_serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               borrow
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] diff;

  // The last difference bit is never stored in res; it is joined on the final edge.
  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    diff    = {d, res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for a new request so back-to-back ops lose no cycle.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          res  <= diff[WIDTH-1:1];
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            out    <= {{WIDTH{br_next}}, diff};
            borrow <= br_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_subtractor.sv
// Self-checking bench for alu_serial_subtractor (WIDTH=4): per-cycle comparison
// against a transaction-level model plus directed literal expectations.
module tb_alu_serial_subtractor;

  localparam int W  = 4;
  localparam int OW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy;
  logic          done;
  logic [OW-1:0] out;
  logic          borrow;

  int checks = 0;
  int errors = 0;

  alu_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op at edge pk is busy for W cycles, then its
  // result appears with a one-cycle done; a new op may be accepted from that cycle.
  int            cyc = 0;
  int            pk = 0;
  int            pa = 0;
  int            pb = 0;
  bit            pend = 1'b0;
  logic [OW-1:0] m_out = '0;
  logic          m_br = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      m_out <= '0;
      m_br  <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (pend && (cyc + 1 == pk + W)) begin
        m_out <= OW'(pa - pb);
        m_br  <= (pa < pb);
      end
      if (start && (!pend || cyc >= pk + W)) begin
        pend <= 1'b1;
        pk   <= cyc + 1;
        pa   <= int'(A);
        pb   <= int'(B);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   64'(busy),   64'(pend && cyc >= pk && cyc < pk + W));
    chk("done",   64'(done),   64'(pend && cyc == pk + W));
    chk("out",    64'(out),    64'(m_out));
    chk("borrow", 64'(borrow), 64'(m_br));
  end

  // One op with literal expectations; optionally pokes start(A=1,B=1) while busy.
  task automatic do_op(input int a, input int b, input logic [OW-1:0] eo,
                       input logic eb, input bit poke);
    int n;
    @(posedge clk); #1;
    start = 1'b1; A = W'(a); B = W'(b);
    @(posedge clk); #1;
    start = 1'b0; A = W'($urandom); B = W'($urandom);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (done) break;
      if (poke && i == 2) begin start = 1'b1; A = W'(1); B = W'(1); end
      if (i == 3) start = 1'b0;
    end
    chk("latency", 64'(n), 64'(5));
    chk("op_out", 64'(out), 64'(eo));
    chk("op_borrow", 64'(borrow), 64'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_borrow", 64'(borrow), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    do_op(9, 3, 8'h06, 1'b0, 1'b0);
    do_op(3, 9, 8'hFA, 1'b1, 1'b1);
    do_op(0, 15, 8'hF1, 1'b1, 1'b0);
    do_op(15, 15, 8'h00, 1'b0, 1'b0);
    do_op(15, 0, 8'h0F, 1'b0, 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(a, b, OW'(a - b), (a < b), ((a + b) % 3) == 0);

    // Back to back: start held through busy and into the DONE cycle.
    @(posedge clk); #1;
    start = 1'b1; A = W'(5); B = W'(2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("b2b_first_seen", 64'(seen), 64'(1));
    chk("b2b_first_out", 64'(out), 64'(8'h03));
    A = W'(2); B = W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (done) break;
    end
    chk("b2b_gap", 64'(n), 64'(5));
    chk("b2b_second_out", 64'(out), 64'(8'hFB));
    chk("b2b_second_borrow", 64'(borrow), 64'(1));

    // Asynchronous reset during the third RUN cycle.
    @(posedge clk); #1;
    start = 1'b1; A = W'(12); B = W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_out", 64'(out), 64'(0));
    chk("arst_borrow", 64'(borrow), 64'(0));
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("no_done_after_abort", 64'(seen), 64'(0));

    // Random start/operand traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) != 0);
      A = W'($urandom);
      B = W'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
